bconv_accumulator: RTL and testbench
====================================

Name: bconv_accumulator

Overview:
Downstream consumer of the 3x3 window/weight circular buffer in the binary-weight CNN datapath. Each valid slice carries nine 6-bit unsigned activations and nine 1-bit weights (1 = +1, 0 = -1). The block forms the signed 3x3 dot product, accumulates ACC_COUNT consecutive slices (one per input channel) into one output pixel, then requantizes that pixel to 6 bits. Output goes to the output line buffer and pooling stage.

Parameters:
DATA_W, 6, activation width (unsigned)
ACC_COUNT, 3, slices accumulated per output pixel (= INPUT_CHANNEL); legal range 1..64
ACC_W, 18, signed accumulator and out_sum width
SHIFT, 2, arithmetic right shift applied before saturation

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  slice valid; driven by the buffer's buffer_done
acc_clr  in  1  synchronous clear of the accumulation in progress
x11..x33  in  DATA_W each  window activations, row-major
w11..w33  in  1 each  binary weights, 1 = +x, 0 = -x
out_valid  out  1  one-cycle pulse when a pixel completes
out_sum  out  ACC_W  signed raw accumulated sum
out_q  out  DATA_W  requantized pixel
busy  out  1  high while a pixel is partially accumulated or slices are in the pipe

Behaviour:
- Reset: all pipeline registers, accumulator and channel counter cleared. out_valid=0, out_sum=0, out_q=0, busy=0. Reset mid-pixel discards the partial sum.
- S1 (edge 1 after the sampled in_valid): p_ij = w_ij ? +x_ij : -x_ij, stored as signed DATA_W+1 bits. v1<=in_valid.
- S2 (edge 2): nine-input signed adder tree, registered. Width DATA_W+5 (range -567..567). v2<=v1.
- S3 (edge 3): when v2 is high:
  - cnt==0: acc<=psum.
  - Otherwise: acc<=acc+psum, sign-extended to ACC_W.
  - cnt wraps at ACC_COUNT-1.
- Completion (cnt==ACC_COUNT-1 and v2): out_sum<=acc+psum, out_q<=quantize(acc+psum), out_valid<=1 for exactly one cycle, cnt<=0.
  - out_sum and out_q hold their values until the next completion.
  - Latency: final in_valid at cycle t gives out_valid in cycle t+3.
- ACC_COUNT==1: every slice produces a pixel.
- Throughput: one slice per cycle, no stalls, no backpressure. Back-to-back pixels need no bubble. The first slice of pixel N+1 loads the accumulator while pixel N's result registers.
- acc_clr: clears cnt, acc, v1 and v2 on the next edge and drops in-flight slices. If acc_clr and in_valid are high together, clear wins and the slice is dropped. acc_clr never suppresses an out_valid already registered.
- Quantize: s = (acc+psum) >>> SHIFT (arithmetic, floor), then saturate per the optional feature.
- busy = v1 | v2 | (cnt!=0).
- ACC_W must hold ACC_COUNT*567 signed. The default covers it; overflow beyond ACC_W is not checked.

Optional Feature:
BCONV_RELU_EN
- Defined: out_q = unsigned clamp of s to [0, 2^DATA_W-1] (ReLU fused).
- Undefined: out_q = two's-complement clamp of s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- out_sum is unaffected in both cases.

Decomposition:
- Package bconv_pkg:
  - DATA_W and PSUM_W=DATA_W+5 constants.
  - Typedef psum_t.
  - Function sat_q(s), with both macro variants.
- Sub-module bconv_adder_tree9: combinational sign-select plus registered two-level tree, covering S1 and S2. Accumulator, counter and quantizer stay in the top.

Test Plan:
- All x=10, all w=1, 3 consecutive valids -> out_valid at t+3 of the 3rd valid; out_sum=270; out_q=63 with RELU, 31 without.
- All x=10, all w=0, 3 valids -> out_sum=-270; s=-68; out_q=0 with RELU, -32 (6'b100000) without.
- x=5, w=9'b000011111, 3 valids -> per-slice psum=5, out_sum=15, out_q=3 in both builds.
- 6 back-to-back valids alternating the first two patterns -> two out_valid pulses 3 cycles apart (270 then -270); no bubble; busy drops 3 cycles after the last valid.
- Two valids, then acc_clr, then 3 fresh valids of all x=1, w=1 -> single out_valid with out_sum=27 (stale partial discarded). acc_clr coincident with in_valid -> that slice is absent from the sum.
- rst_n asserted after 2 of 3 slices, then released -> all outputs 0 immediately; the next 3 valids (x=1, w=1) produce out_sum=27.

Source files
------------

// File: rtl/bconv_pkg.sv
// Shared widths, partial-sum type and output requantizer for the binary-weight conv accumulator.
// Build option BCONV_RELU_EN: defined gives a ReLU-fused unsigned clamp, undefined a signed clamp.
package bconv_pkg;

    localparam int DATA_W   = 6;
    localparam int PSUM_W   = DATA_W + 5;
    localparam int SAT_IN_W = 32;

    typedef logic signed [DATA_W:0]   prod_t;
    typedef logic signed [PSUM_W-1:0] psum_t;

    function automatic logic [DATA_W-1:0] sat_q(input logic signed [SAT_IN_W-1:0] s);
        logic [DATA_W-1:0] q;
`ifdef BCONV_RELU_EN
        localparam int U_MAX = (1 << DATA_W) - 1;
        if (s < 0)
            q = '0;
        else if (s > U_MAX)
            q = '1;
        else
            q = s[DATA_W-1:0];
`else
        localparam int S_MAX = (1 << (DATA_W - 1)) - 1;
        localparam int S_MIN = -(1 << (DATA_W - 1));
        if (s < S_MIN)
            q = {1'b1, {(DATA_W-1){1'b0}}};
        else if (s > S_MAX)
            q = {1'b0, {(DATA_W-1){1'b1}}};
        else
            q = s[DATA_W-1:0];
`endif
        return q;
    endfunction

endpackage

// File: rtl/bconv_adder_tree9.sv
// Sign-select of nine activations by binary weights, then a registered nine-input signed sum.
// Two cycles in to psum; no backpressure, clr kills both valid stages on the next edge.
module bconv_adder_tree9
    import bconv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   clr,
    input  logic [8:0][DATA_W-1:0] x,
    input  logic [8:0]             w,
    output psum_t                  psum,
    output logic                   v1,
    output logic                   v2
);

    prod_t p [9];
    psum_t grp [3];
    psum_t tree_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++)
                p[i] <= '0;
            psum <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++)
                p[i] <= w[i] ? prod_t'({1'b0, x[i]}) : -prod_t'({1'b0, x[i]});
            psum <= tree_sum;
            v1   <= in_valid & ~clr;
            v2   <= v1 & ~clr;
        end
    end

    // Row sums first, then the sum of rows: two adder levels ahead of the psum register.
    always_comb begin
        for (int g = 0; g < 3; g++)
            grp[g] = psum_t'(p[3*g]) + psum_t'(p[3*g+1]) + psum_t'(p[3*g+2]);
        tree_sum = grp[0] + grp[1] + grp[2];
    end

endmodule

// File: rtl/bconv_accumulator.sv
// Accumulates ACC_COUNT binary 3x3 dot products per pixel, requantizes to DATA_W (BCONV_RELU_EN selects ReLU clamp).
// Last slice in at t gives out_valid at t+3; one slice per cycle, no stalls or backpressure.
module bconv_accumulator
    import bconv_pkg::*;
#(
    parameter int ACC_COUNT = 3,
    parameter int ACC_W     = 18,
    parameter int SHIFT     = 2
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    acc_clr,
    input  logic [DATA_W-1:0]       x11,
    input  logic [DATA_W-1:0]       x12,
    input  logic [DATA_W-1:0]       x13,
    input  logic [DATA_W-1:0]       x21,
    input  logic [DATA_W-1:0]       x22,
    input  logic [DATA_W-1:0]       x23,
    input  logic [DATA_W-1:0]       x31,
    input  logic [DATA_W-1:0]       x32,
    input  logic [DATA_W-1:0]       x33,
    input  logic                    w11,
    input  logic                    w12,
    input  logic                    w13,
    input  logic                    w21,
    input  logic                    w22,
    input  logic                    w23,
    input  logic                    w31,
    input  logic                    w32,
    input  logic                    w33,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [DATA_W-1:0]       out_q,
    output logic                    busy
);

    localparam int CNT_W = (ACC_COUNT > 1) ? $clog2(ACC_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_COUNT - 1);

    logic [8:0][DATA_W-1:0] x_vec;
    logic [8:0]             w_vec;
    psum_t                  psum;
    logic                   v1;
    logic                   v2;

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] sum_next;
    logic signed [ACC_W-1:0] shifted;
    logic                    pixel_done;

    assign x_vec = {x33, x32, x31, x23, x22, x21, x13, x12, x11};
    assign w_vec = {w33, w32, w31, w23, w22, w21, w13, w12, w11};

    bconv_adder_tree9 u_tree (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .clr      (acc_clr),
        .x        (x_vec),
        .w        (w_vec),
        .psum     (psum),
        .v1       (v1),
        .v2       (v2)
    );

    // The first slice of a pixel loads rather than adds, so no bubble is needed between pixels.
    assign psum_ext   = ACC_W'(psum);
    assign sum_next   = (cnt == '0) ? psum_ext : acc + psum_ext;
    assign shifted    = sum_next >>> SHIFT;
    assign pixel_done = v2 && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_q     <= '0;
        end else if (acc_clr) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= pixel_done;
            if (v2) begin
                acc <= sum_next;
                cnt <= pixel_done ? '0 : cnt + 1'b1;
            end
            if (pixel_done) begin
                out_sum <= sum_next;
                out_q   <= sat_q(SAT_IN_W'(shifted));
            end
        end
    end

    assign busy = v1 | v2 | (cnt != '0);

endmodule

// File: tb/tb_bconv_accumulator.sv
// Randomized scoreboard bench: a per-pixel arithmetic model queues expected pixels, a monitor checks them.
`timescale 1ns/1ps
module tb_bconv_accumulator;

    localparam int DW   = 6;
    localparam int AC   = 3;
    localparam int AW   = 18;
    localparam int SH   = 2;
    localparam int NCYC = 8192;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 acc_clr = 1'b0;
    logic [8:0][DW-1:0]   xa = '0;
    logic [8:0]           wv = '0;
    logic                 out_valid;
    logic                 busy;
    logic [AW-1:0]        out_sum;
    logic [DW-1:0]        out_q;

    always #5 clk = ~clk;

    bconv_accumulator #(.ACC_COUNT(AC), .ACC_W(AW), .SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .acc_clr(acc_clr),
        .x11(xa[0]), .x12(xa[1]), .x13(xa[2]),
        .x21(xa[3]), .x22(xa[4]), .x23(xa[5]),
        .x31(xa[6]), .x32(xa[7]), .x33(xa[8]),
        .w11(wv[0]), .w12(wv[1]), .w13(wv[2]),
        .w21(wv[3]), .w22(wv[4]), .w23(wv[5]),
        .w31(wv[6]), .w32(wv[7]), .w33(wv[8]),
        .out_valid(out_valid), .out_sum(out_sum), .out_q(out_q), .busy(busy)
    );

    typedef struct {
        int            sum;
        logic [DW-1:0] q;
        int            cyc;
    } exp_t;

    exp_t          expq[$];
    exp_t          e_mon;
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            m_sum = 0;
    int            m_cnt = 0;
    int            hist[NCYC];
    bit            issued[NCYC];
    int            last_sum = 0;
    logic [DW-1:0] last_q = '0;
    bit            mon_en = 1'b0;
    int            bexp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Floor division by 2^SH followed by the build's clamp range.
    function automatic logic [DW-1:0] q_ref(input int s);
        int d;
        int f;
        d = 1 << SH;
        f = (s >= 0) ? s / d : -((-s + d - 1) / d);
`ifdef BCONV_RELU_EN
        if (f < 0) f = 0;
        if (f > (1 << DW) - 1) f = (1 << DW) - 1;
`else
        if (f < -(1 << (DW - 1))) f = -(1 << (DW - 1));
        if (f > (1 << (DW - 1)) - 1) f = (1 << (DW - 1)) - 1;
`endif
        return DW'(f);
    endfunction

    // One cycle of stimulus; the model counts a slice when it is issued and clr does not kill it.
    task automatic step(input bit v, input bit clr, input logic [8:0][DW-1:0] xs, input logic [8:0] ws);
        int   dsum;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        acc_clr  = clr;
        xa       = xs;
        wv       = ws;
        dsum = 0;
        for (int i = 0; i < 9; i++)
            dsum += ws[i] ? int'(xs[i]) : -int'(xs[i]);
        if (clr) begin
            m_sum = 0;
            m_cnt = 0;
            if (cyc >= 2) begin
                hist[cyc-2] = 0;
                hist[cyc-1] = 0;
            end
        end else if (v) begin
            m_sum += dsum;
            m_cnt++;
            if (m_cnt == AC) begin
                e.sum = m_sum;
                e.q   = q_ref(m_sum);
                e.cyc = cyc + 3;
                expq.push_back(e);
                m_sum = 0;
                m_cnt = 0;
            end
        end
        hist[cyc]   = m_cnt;
        issued[cyc] = v && !clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        m_sum    = 0;
        m_cnt    = 0;
        expq.delete();
        last_sum = 0;
        last_q   = '0;
        for (int i = 0; i < 4; i++)
            if (cyc - i >= 0) begin
                hist[cyc-i]   = 0;
                issued[cyc-i] = 1'b0;
            end
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'($signed(out_sum)), 0);
        check("rst_out_q", int'(out_q), 0);
        check("rst_busy", int'(busy), 0);
        idle(2);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            bexp = ((cyc >= 1 && issued[cyc-1]) || (cyc >= 2 && issued[cyc-2]) ||
                    (cyc >= 3 && hist[cyc-3] != 0)) ? 1 : 0;
            check("busy", int'(busy), bexp);
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_pixel: no out_valid at cycle %0d, expected sum %0d", expq[0].cyc, expq[0].sum);
                void'(expq.pop_front());
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_pixel: out_valid with sum %0d, expected none (cycle %0d)", $signed(out_sum), cyc);
                end else begin
                    e_mon = expq.pop_front();
                    check("out_sum", int'($signed(out_sum)), e_mon.sum);
                    check("out_q", int'(out_q), int'(e_mon.q));
                    check("latency", cyc, e_mon.cyc);
                    last_sum = e_mon.sum;
                    last_q   = e_mon.q;
                end
            end else begin
                check("hold_sum", int'($signed(out_sum)), last_sum);
                check("hold_q", int'(out_q), int'(last_q));
            end
        end
    end

    logic [8:0][DW-1:0] pat10;
    logic [8:0][DW-1:0] pat5;
    logic [8:0][DW-1:0] pat1;
    logic [8:0][DW-1:0] xr;
    logic [8:0]         wr;
    bit                 rv;
    bit                 rc;
    int                 idle_run;

    initial begin
        pat10 = {9{6'd10}};
        pat5  = {9{6'd5}};
        pat1  = {9{6'd1}};

        #2;
        check("init_out_valid", int'(out_valid), 0);
        check("init_out_sum", int'($signed(out_sum)), 0);
        check("init_out_q", int'(out_q), 0);
        check("init_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        repeat (3) step(1'b1, 1'b0, pat10, '1);
        idle(4);
        repeat (3) step(1'b1, 1'b0, pat10, '0);
        idle(4);
        repeat (3) step(1'b1, 1'b0, pat5, 9'b000011111);
        idle(4);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, pat10, (i < 3) ? 9'h1FF : 9'h000);
        idle(5);

        repeat (2) step(1'b1, 1'b0, pat10, '1);
        idle(2);
        step(1'b0, 1'b1, '0, '0);
        step(1'b1, 1'b1, pat10, '1);
        repeat (3) step(1'b1, 1'b0, pat1, '1);
        idle(4);

        repeat (2) step(1'b1, 1'b0, pat10, '1);
        do_reset();
        repeat (3) step(1'b1, 1'b0, pat1, '1);
        idle(4);

        idle_run = 2;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 9; i++)
                xr[i] = DW'($urandom_range(0, 63));
            wr = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) begin
                xr = {9{6'd63}};
                wr = ($urandom_range(0, 1) == 1) ? 9'h1FF : 9'h000;
            end
            rv = ($urandom_range(0, 3) != 0);
            rc = (idle_run >= 2) && ($urandom_range(0, 11) == 0);
            step(rv, rc, xr, wr);
            idle_run = (rv && !rc) ? 0 : idle_run + 1;
        end
        idle(6);

        check("pending_pixels", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
